alu_ex_stage: RTL and testbench

ALU_EX_STAGE -- requirements
Module: alu_ex_stage

---
 rtl/alu_ex_stage.sv | 143 ++++++++++++++
 tb/tb_alu_ex_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: single-entry execute stage for RV32I-style integer ALU ops.
//   A decode-side valid/ready pair feeds one registered result slot that
//   drains through a writeback-side valid/ready pair (latency 1, no skid).
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   flush                 kills the held result and any same-cycle input
//   in_valid / in_ready   decode handshake (in_ready is combinational)
//   rs1_val, rs2_val      register operands
//   imm, use_imm          immediate and operand-2 select
//   funct3, funct7_bit5   operation select
//   rs1_addr, rs2_addr    source addresses (used only for forwarding)
//   rd_addr               destination address
//   out_valid / out_ready writeback handshake
//   out_result, out_rd, out_we  registered result payload
//   op_count              number of results accepted by writeback (wraps)
//
// Build option:
//   ALU_EX_FWD_EN  when defined, the held result is forwarded to a source
//                  operand whose address matches out_rd (and out_we is set).
module alu_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [2:0]      funct3,
  input  logic            funct7_bit5,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic [RA_W-1:0] rs2_addr,
  input  logic [RA_W-1:0] rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RA_W-1:0] out_rd,
  output logic            out_we,
  output logic [31:0]     op_count
);

  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CNT_W   = 32;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept_c;
  logic             drain_c;
  logic [XLEN-1:0]  op1_c;
  logic [XLEN-1:0]  op2_c;
  logic [XLEN-1:0]  alu_c;
  logic [SHAMT_W-1:0] shamt_c;

  // Handshake: the slot can take a new op when empty or draining this cycle
  assign in_ready = !valid_q || out_ready;
  assign accept_c = in_valid && in_ready && !flush;
  assign drain_c  = valid_q && out_ready;

`ifdef ALU_EX_FWD_EN
  // Operand select with bypass from the held result (x0 never has we set)
  always_comb begin
    op1_c = rs1_val;
    op2_c = use_imm ? imm : rs2_val;
    if (valid_q && we_q && (rs1_addr == rd_q)) op1_c = result_q;
    if (!use_imm && valid_q && we_q && (rs2_addr == rd_q)) op2_c = result_q;
  end
`else
  // Operand select without bypass; source addresses are not needed here
  logic unused_src_addr;
  assign unused_src_addr = ^{rs1_addr, rs2_addr};
  assign op1_c = rs1_val;
  assign op2_c = use_imm ? imm : rs2_val;
`endif

  assign shamt_c = op2_c[SHAMT_W-1:0];

  // ALU: only the low five bits of operand 2 form the shift amount
  always_comb begin
    alu_c = '0;
    case (funct3)
      3'b000: alu_c = (funct7_bit5 && !use_imm) ? (op1_c - op2_c) : (op1_c + op2_c);
      3'b001: alu_c = op1_c << shamt_c;
      3'b010: alu_c = XLEN'($signed(op1_c) < $signed(op2_c));
      3'b011: alu_c = XLEN'(op1_c < op2_c);
      3'b100: alu_c = op1_c ^ op2_c;
      3'b101: alu_c = funct7_bit5 ? $unsigned($signed(op1_c) >>> shamt_c)
                                  : (op1_c >> shamt_c);
      3'b110: alu_c = op1_c | op2_c;
      3'b111: alu_c = op1_c & op2_c;
      default: alu_c = '0;
    endcase
  end

  // Next state: a new accept wins over drain; flush empties the slot
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    count_d  = drain_c ? (count_q + CNT_W'(1)) : count_q;
    if (accept_c) begin
      valid_d  = 1'b1;
      result_d = alu_c;
      rd_d     = rd_addr;
      we_d     = (rd_addr != '0);
    end else if (flush || drain_c) begin
      valid_d  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      count_q  <= count_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_we     = we_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed scenarios plus a randomized
// run scored against a transaction-level reference model.
module tb_alu_ex_stage;

  logic        clk, rst, flush, in_valid, in_ready;
  logic [31:0] rs1_val, rs2_val, imm;
  logic        use_imm, funct7_bit5;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        out_valid, out_ready, out_we;
  logic [31:0] out_result, op_count;
  logic [4:0]  out_rd;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } txn_t;
  txn_t q[$];

  alu_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .use_imm(use_imm),
    .funct3(funct3), .funct7_bit5(funct7_bit5),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference ALU from instruction semantics, using plain arithmetic
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic f7,
                                          input logic ui);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    r  = 32'd0;
    case (f3)
      3'd0: r = (f7 && !ui) ? (a + (~b) + 32'd1) : (a + b);
      3'd1: r = a << sh;
      3'd2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (f7 && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic ui, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] ra1, input logic [4:0] ra2);
    rs1_val = a; rs2_val = b; imm = im; use_imm = ui; funct3 = f3; funct7_bit5 = f7;
    rd_addr = rd; rs1_addr = ra1; rs2_addr = ra2;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    set_op(32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0);
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", out_result); end
    n_cmp++; if (out_rd !== 5'd0 || out_we !== 1'b0) begin n_bad++; $display("FAIL reset_rd_we got %0d/%0b want 0/0", out_rd, out_we); end
    n_cmp++; if (op_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", op_count); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    exp_cnt = 32'd0;
  endtask

  task automatic test_shift();
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(32'h8000_0000, 32'd0, 32'd4, 1'b1, 3'd5, 1'b1, 5'd1, 5'd0, 5'd0);
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'hF800_0000) begin n_bad++; $display("FAIL sra got v=%0b %h want v=1 f8000000", out_valid, out_result); end
    n_cmp++; if (out_rd !== 5'd1 || out_we !== 1'b1) begin n_bad++; $display("FAIL sra_rd got %0d/%0b want 1/1", out_rd, out_we); end
    funct7_bit5 = 1'b0;
    step(); exp_cnt++;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h0800_0000) begin n_bad++; $display("FAIL srl got v=%0b %h want v=1 08000000", out_valid, out_result); end
    in_valid = 1'b0;
    step(); exp_cnt++;
    n_cmp++; if (out_valid !== 1'b0 || op_count !== exp_cnt) begin n_bad++; $display("FAIL shift_drain got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, op_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 1'b1, 5'd2, 5'd0, 5'd0);
    step();
    n_cmp++; if (out_result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub got %h want fffffffe", out_result); end
    funct3 = 3'd2;
    step(); exp_cnt++;
    n_cmp++; if (out_result !== 32'd1) begin n_bad++; $display("FAIL slt got %h want 1", out_result); end
    set_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd3, 1'b0, 5'd2, 5'd0, 5'd0);
    step(); exp_cnt++;
    n_cmp++; if (out_result !== 32'd0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL sltu got v=%0b %h want v=1 0", out_valid, out_result); end
    in_valid = 1'b0;
    step(); exp_cnt++;
    n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(32'd1, 32'd2, 32'd0, 1'b0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0);
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd3) begin n_bad++; $display("FAIL stall_load got v=%0b %h want v=1 3", out_valid, out_result); end
    set_op(32'hF0, 32'h0F, 32'd0, 1'b0, 3'd4, 1'b0, 5'd4, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c%0d got %0b want 0", i, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd !== 5'd2 || out_we !== 1'b1)
        begin n_bad++; $display("FAIL stall_hold c%0d got v=%0b %h rd=%0d we=%0b want 1 3 2 1", i, out_valid, out_result, out_rd, out_we); end
      n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL stall_count c%0d got %0d want %0d", i, op_count, exp_cnt); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    step(); exp_cnt++;
    n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL release_count got %0d want %0d", op_count, exp_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'hFF || out_rd !== 5'd4) begin n_bad++; $display("FAIL release_next got v=%0b %h rd=%0d want 1 ff 4", out_valid, out_result, out_rd); end
    in_valid = 1'b0;
    step(); exp_cnt++;
    n_cmp++; if (out_valid !== 1'b0 || op_count !== exp_cnt) begin n_bad++; $display("FAIL stall_drain got v=%0b cnt=%0d want 0 %0d", out_valid, op_count, exp_cnt); end
  endtask

  task automatic test_rd_zero();
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(32'd1, 32'd1, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_we !== 1'b0) begin n_bad++; $display("FAIL rd_zero got v=%0b %h we=%0b want 1 2 0", out_valid, out_result, out_we); end
    in_valid = 1'b0;
    step(); exp_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(32'd2, 32'd3, 32'd0, 1'b0, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0);
    step();
    flush = 1'b1;
    set_op(32'd9, 32'd9, 32'd0, 1'b0, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0);
    step();
    n_cmp++; if (out_valid !== 1'b0 || op_count !== exp_cnt) begin n_bad++; $display("FAIL flush_stalled got v=%0b cnt=%0d want 0 %0d", out_valid, op_count, exp_cnt); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_load got v=%0b want 0", out_valid); end
    // flush on a draining edge: transfer is still counted
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b1;
    step(); exp_cnt++;
    n_cmp++; if (out_valid !== 1'b0 || op_count !== exp_cnt) begin n_bad++; $display("FAIL flush_drain got v=%0b cnt=%0d want 0 %0d", out_valid, op_count, exp_cnt); end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(32'd40, 32'd2, 32'd0, 1'b0, 3'd6, 1'b0, 5'd7, 5'd0, 5'd0);
    step();
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_we !== 1'b0 || op_count !== 32'd0)
      begin n_bad++; $display("FAIL rst_stall got v=%0b %h rd=%0d we=%0b cnt=%0d want all 0", out_valid, out_result, out_rd, out_we, op_count); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_stall_in_ready got %0b want 1", in_ready); end
    exp_cnt = 32'd0;
  endtask

  task automatic test_forward();
    logic [31:0] want;
`ifdef ALU_EX_FWD_EN
    want = 32'd20;
`else
    want = 32'd0;
`endif
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(32'd10, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0);
    step();
    set_op(32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd5, 5'd3, 5'd3);
    step(); exp_cnt++;
    n_cmp++; if (out_result !== want) begin n_bad++; $display("FAIL forward got %0d want %0d", out_result, want); end
    in_valid = 1'b0;
    step(); exp_cnt++;
  endtask

  task automatic test_random();
    txn_t t;
    logic [31:0] a, b;
    logic acc, drn, rdy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_valid cyc%0d got %0b want %0b", cyc, out_valid, q.size() != 0); end
      n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL rand_count cyc%0d got %0d want %0d", cyc, op_count, exp_cnt); end
      if (q.size() != 0) begin
        n_cmp++; if (out_result !== q[0].res || out_rd !== q[0].rd || out_we !== q[0].we)
          begin n_bad++; $display("FAIL rand_data cyc%0d got %h rd=%0d we=%0b want %h rd=%0d we=%0b", cyc, out_result, out_rd, out_we, q[0].res, q[0].rd, q[0].we); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_op($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      #1;
      rdy = (q.size() == 0) || out_ready;
      n_cmp++; if (in_ready !== rdy) begin n_bad++; $display("FAIL rand_in_ready cyc%0d got %0b want %0b", cyc, in_ready, rdy); end
      acc = in_valid && rdy;
      drn = (q.size() != 0) && out_ready;
      if (acc) begin
        a = rs1_val;
        b = use_imm ? imm : rs2_val;
`ifdef ALU_EX_FWD_EN
        if (q.size() != 0 && q[0].we) begin
          if (rs1_addr == q[0].rd) a = q[0].res;
          if (!use_imm && rs2_addr == q[0].rd) b = q[0].res;
        end
`endif
        t.res = ref_alu(a, b, funct3, funct7_bit5, use_imm);
        t.rd  = rd_addr;
        t.we  = (rd_addr != 5'd0);
      end
      if (drn) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (acc) q.push_back(t);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    if (q.size() != 0) exp_cnt++;
    q.delete();
    n_cmp++; if (out_valid !== 1'b0 || op_count !== exp_cnt) begin n_bad++; $display("FAIL rand_final got v=%0b cnt=%0d want 0 %0d", out_valid, op_count, exp_cnt); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_shift();
    test_back_to_back();
    test_stall();
    test_rd_zero();
    test_flush();
    test_reset_mid_stall();
    test_forward();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
